// File: rtl/cnn_rst_pkg.sv
// Shared types and sizing helpers for the CNN accelerator reset-release sequencer.
package cnn_rst_pkg;

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_INIT    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_FAIL    = 3'd4
  } rst_seq_state_e;

  localparam int HOLD_CYCLES_DEF  = 16;
  localparam int STAGE_GAP_DEF    = 4;
  localparam int INIT_TIMEOUT_DEF = 1024;

  // One shared counter serves every phase, so it must hold the largest terminal value.
  function automatic int cnt_width(input int hold_cycles, input int stage_gap, input int init_timeout);
    int w;
    w = $clog2(hold_cycles);
    if ($clog2(stage_gap) > w) w = $clog2(stage_gap);
    if ($clog2(init_timeout) > w) w = $clog2(init_timeout);
    if (w < 1) w = 1;
    return w;
  endfunction

  localparam int CNT_W_DEF = cnt_width(HOLD_CYCLES_DEF, STAGE_GAP_DEF, INIT_TIMEOUT_DEF);

endpackage

// File: rtl/rst_sequencer_sat_counter.sv
// Up-counter with synchronous clear that sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // clear beats enable; saturation holds the top value
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= {WIDTH{1'b0}};
    end else if (enable && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Reset-release sequencer: hold, memory-init handshake, staged domain release, run/uptime.
module rst_sequencer
  import cnn_rst_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_GAP    = 4,
  parameter int INIT_TIMEOUT = 1024,
  parameter int UPTIME_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sw_rst_i,
  output logic                  init_req_o,
  input  logic                  init_done_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  ready_o,
  output logic                  timeout_o,
  output logic [UPTIME_W-1:0]   uptime_o
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP, INIT_TIMEOUT);
  localparam int K_W   = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(NUM_STAGES);

  rst_seq_state_e   state;
  logic [K_W-1:0]   k;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clear;
  logic             cnt_en;
  logic             up_clear;
  logic             up_en;

  // Phase counter control: clear on every state change, count while dwelling.
  always_comb begin
    cnt_clear = 1'b1;
    cnt_en    = 1'b0;
    if (rst_i || sw_rst_i) begin
      cnt_clear = 1'b1;
    end else begin
      case (state)
        S_HOLD:    begin cnt_clear = (cnt == HOLD_LAST); cnt_en = 1'b1; end
        S_INIT:    begin cnt_clear = init_done_i || (cnt == TO_LAST); cnt_en = 1'b1; end
        S_RELEASE: begin cnt_clear = (cnt == GAP_LAST); cnt_en = 1'b1; end
        default:   begin cnt_clear = 1'b1; cnt_en = 1'b0; end
      endcase
    end
  end

  // Uptime is zero on the edge ready rises and counts only while already running.
  always_comb begin
    up_clear = rst_i || sw_rst_i || (state != S_RUN);
    up_en    = (state == S_RUN);
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk    (clk_i),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (cnt)
  );

  sat_counter #(.WIDTH(UPTIME_W)) u_uptime (
    .clk    (clk_i),
    .clear  (up_clear),
    .enable (up_en),
    .count  (uptime_o)
  );

  // Sequencer FSM; timeout is sticky across soft reset and only rst_i clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_HOLD;
      k           <= {K_W{1'b0}};
      stage_rst_o <= {NUM_STAGES{1'b1}};
      init_req_o  <= 1'b0;
      ready_o     <= 1'b0;
      timeout_o   <= 1'b0;
    end else if (sw_rst_i) begin
      state       <= S_HOLD;
      k           <= {K_W{1'b0}};
      stage_rst_o <= {NUM_STAGES{1'b1}};
      init_req_o  <= 1'b0;
      ready_o     <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state      <= S_INIT;
            init_req_o <= 1'b1;
          end
        end
        S_INIT: begin
          if (init_done_i) begin
            state          <= S_RELEASE;
            init_req_o     <= 1'b0;
            stage_rst_o[0] <= 1'b0;
            k              <= K_W'(1);
          end else if (cnt == TO_LAST) begin
            state      <= S_FAIL;
            init_req_o <= 1'b0;
            timeout_o  <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt == GAP_LAST) begin
            if (k == K_LAST) begin
              state   <= S_RUN;
              ready_o <= 1'b1;
            end else begin
              stage_rst_o[k] <= 1'b0;
              k              <= k + K_W'(1);
            end
          end
        end
        S_RUN: begin
          ready_o <= 1'b1;
        end
        S_FAIL: begin
          stage_rst_o <= {NUM_STAGES{1'b1}};
          ready_o     <= 1'b0;
        end
        default: begin
          state       <= S_HOLD;
          stage_rst_o <= {NUM_STAGES{1'b1}};
          init_req_o  <= 1'b0;
          ready_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer; a second instance with a 4-bit uptime checks saturation.
module tb_rst_sequencer;

  logic       clk;
  logic       rst;
  logic       sw_rst;
  logic       done;
  logic       init_req;
  logic [2:0] stage_rst;
  logic       ready;
  logic       timeout;
  logic [31:0] uptime;
  logic       init_req4;
  logic [2:0] stage_rst4;
  logic       ready4;
  logic       timeout4;
  logic [3:0] uptime4;

  int n_chk  = 0;
  int n_fail = 0;

  rst_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(16), .STAGE_GAP(4), .INIT_TIMEOUT(1024), .UPTIME_W(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sw_rst_i(sw_rst), .init_req_o(init_req), .init_done_i(done),
    .stage_rst_o(stage_rst), .ready_o(ready), .timeout_o(timeout), .uptime_o(uptime)
  );

  rst_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(16), .STAGE_GAP(4), .INIT_TIMEOUT(1024), .UPTIME_W(4)
  ) dut4 (
    .clk_i(clk), .rst_i(rst), .sw_rst_i(sw_rst), .init_req_o(init_req4), .init_done_i(done),
    .stage_rst_o(stage_rst4), .ready_o(ready4), .timeout_o(timeout4), .uptime_o(uptime4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sw_rst = 1'b0; done = 1'b0;
    tick(5);
    chk("rst_stage", 32'(stage_rst), 32'h7);
    chk("rst_req", 32'(init_req), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_uptime", uptime, 32'h0);

    // Basic sequence; edges numbered from reset release
    rst = 1'b0;
    tick(15);
    chk("e15_req", 32'(init_req), 32'h0);
    tick(1);
    chk("e16_req", 32'(init_req), 32'h1);
    tick(2);
    chk("e18_stage", 32'(stage_rst), 32'h7);
    done = 1'b1;
    tick(1);
    chk("e19_stage", 32'(stage_rst), 32'h6);
    chk("e19_req", 32'(init_req), 32'h0);
    done = 1'b0;
    tick(3);
    chk("e22_stage", 32'(stage_rst), 32'h6);
    tick(1);
    chk("e23_stage", 32'(stage_rst), 32'h4);
    tick(4);
    chk("e27_stage", 32'(stage_rst), 32'h0);
    chk("e27_ready", 32'(ready), 32'h0);
    tick(3);
    chk("e30_ready", 32'(ready), 32'h0);
    tick(1);
    chk("e31_ready", 32'(ready), 32'h1);
    chk("e31_uptime", uptime, 32'd0);
    tick(4);
    chk("e35_uptime", uptime, 32'd4);
    chk("e35_uptime4", 32'(uptime4), 32'd4);
    tick(96);
    chk("e131_uptime", uptime, 32'd100);
    chk("sat_uptime4", 32'(uptime4), 32'd15);
    tick(3);
    chk("sat_hold_uptime4", 32'(uptime4), 32'd15);

    // Soft reset while running (uptime now 103)
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    chk("sw_stage", 32'(stage_rst), 32'h7);
    chk("sw_ready", 32'(ready), 32'h0);
    chk("sw_uptime", uptime, 32'd0);
    chk("sw_uptime4", 32'(uptime4), 32'd0);
    tick(15);
    chk("sw_e15_req", 32'(init_req), 32'h0);
    tick(1);
    chk("sw_e16_req", 32'(init_req), 32'h1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("sw_rel_stage", 32'(stage_rst), 32'h6);
    tick(11);
    chk("sw_ready_pre", 32'(ready), 32'h0);
    tick(1);
    chk("sw_ready_up", 32'(ready), 32'h1);

    // Hard reset one edge after stage 0 release
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(16);
    chk("r_req", 32'(init_req), 32'h1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("r_stage0", 32'(stage_rst), 32'h6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("r_stage", 32'(stage_rst), 32'h7);
    chk("r_req0", 32'(init_req), 32'h0);
    chk("r_ready", 32'(ready), 32'h0);
    chk("r_uptime", uptime, 32'd0);

    // done held high through HOLD is ignored; release on first INIT edge
    done = 1'b1;
    tick(15);
    chk("dh_e15_req", 32'(init_req), 32'h0);
    chk("dh_e15_stage", 32'(stage_rst), 32'h7);
    tick(1);
    chk("dh_e16_req", 32'(init_req), 32'h1);
    chk("dh_e16_stage", 32'(stage_rst), 32'h7);
    tick(1);
    chk("dh_e17_stage", 32'(stage_rst), 32'h6);
    chk("dh_e17_req", 32'(init_req), 32'h0);
    done = 1'b0;

    // Init timeout
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(16);
    chk("to_req", 32'(init_req), 32'h1);
    tick(1023);
    chk("to_e1039_timeout", 32'(timeout), 32'h0);
    chk("to_e1039_req", 32'(init_req), 32'h1);
    tick(1);
    chk("to_timeout", 32'(timeout), 32'h1);
    chk("to_req0", 32'(init_req), 32'h0);
    chk("to_stage", 32'(stage_rst), 32'h7);
    chk("to_ready", 32'(ready), 32'h0);
    done = 1'b1;
    tick(3);
    done = 1'b0;
    chk("fail_ignores_done", 32'(stage_rst), 32'h7);
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    chk("to_sw_timeout", 32'(timeout), 32'h1);
    chk("to_sw_req", 32'(init_req), 32'h0);
    tick(15);
    chk("to_sw_e15_req", 32'(init_req), 32'h0);
    tick(1);
    chk("to_sw_e16_req", 32'(init_req), 32'h1);
    chk("to_sw_e16_timeout", 32'(timeout), 32'h1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("to_rst_clears", 32'(timeout), 32'h0);

    // done on exactly the last INIT edge wins over timeout
    tick(16);
    tick(1023);
    chk("last_req", 32'(init_req), 32'h1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    chk("last_stage", 32'(stage_rst), 32'h6);
    chk("last_timeout", 32'(timeout), 32'h0);
    chk("last_req0", 32'(init_req), 32'h0);

    // Soft reset held high keeps the block in HOLD
    sw_rst = 1'b1;
    tick(20);
    chk("swh_req", 32'(init_req), 32'h0);
    chk("swh_stage", 32'(stage_rst), 32'h7);
    sw_rst = 1'b0;
    tick(15);
    chk("swh_e15_req", 32'(init_req), 32'h0);
    tick(1);
    chk("swh_e16_req", 32'(init_req), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Synthesizable reset-release sequencer at the top of the CNN accelerator. It consumes the system clock and a synchronous reset and holds every downstream domain in reset. It runs a memory-init handshake, then releases the domain resets one at a time in fixed order (stage 0 = buffers/memories, higher stages = conv/pool/FC datapath) and flags when the design is running. It also provides soft reset, an init timeout error and an uptime counter.

## Interface
- NUM_STAGES, 3, number of staged domain resets (≥1)
- HOLD_CYCLES, 16, cycles rst_i must be low before init starts (≥1)
- STAGE_GAP, 4, cycles between consecutive stage releases, and from the last release to ready (≥1)
- INIT_TIMEOUT, 1024, max cycles in INIT waiting for init_done_i (≥1)
- UPTIME_W, 32, width of uptime_o
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- sw_rst_i  in  1  soft reset request, sampled each edge
- init_req_o  out  1  request to memory-init engine, level
- init_done_i  in  1  init engine acknowledge
- stage_rst_o  out  NUM_STAGES  per-domain resets, active-high, registered
- ready_o  out  1  all stages released, design running
- timeout_o  out  1  sticky init-timeout error
- uptime_o  out  UPTIME_W  edges since ready_o rose, saturating

## Operation
- States: HOLD, INIT, RELEASE, RUN, FAIL. Internal counter cnt, stage index k.
- rst_i high at an edge: state=HOLD, cnt=0, k=0. Outputs: stage_rst_o all ones, init_req_o=0, ready_o=0, timeout_o=0, uptime_o=0. rst_i has priority over everything.
- HOLD: cnt increments each edge. On the HOLD_CYCLES-th edge → INIT, init_req_o=1, cnt=0.
- INIT: init_done_i sampled only here. Done=1 → RELEASE, init_req_o=0, stage_rst_o[0]=0, k=1, cnt=0. Otherwise cnt++. On the INIT_TIMEOUT-th edge with done=0 → FAIL, init_req_o=0, timeout_o=1. Done and timeout on the same edge → done wins.
- RELEASE: every STAGE_GAP edges, stage_rst_o[k] clears and k++. STAGE_GAP edges after the last stage clears → RUN, ready_o=1.
- RUN: uptime_o increments each edge and saturates at all ones. Stays in RUN until a reset.
- FAIL: all stages held, ready_o=0. Exits only via rst_i or sw_rst_i.
- sw_rst_i=1 (rst_i=0), any state: next edge state=HOLD. Stages all ones, init_req_o=0, ready_o=0, uptime_o=0, cnt=0. timeout_o is not cleared; only rst_i clears it. sw_rst_i held high keeps the block in HOLD with cnt=0.
- init_done_i outside INIT is ignored, including when already high on INIT entry before the first INIT edge.
- Stages release strictly in ascending index. A released stage is never re-asserted except by rst_i or sw_rst_i.

## Timing
- All outputs are registered; no combinational input→output path.
- init_req_o rises on the HOLD_CYCLES-th edge sampling rst_i=0 and sw_rst_i=0.
- Edge E samples done=1 → after E, stage_rst_o[0]=0 and init_req_o=0. stage_rst_o[k] clears at E+k·STAGE_GAP. ready_o rises at E+NUM_STAGES·STAGE_GAP.
- uptime_o=0 on the ready_o-rise edge, then +1 per edge.
- Reset or soft reset takes effect on the sampling edge (1-cycle latency).

## Structure
- Package cnn_rst_pkg: typedef enum rst_seq_state_e {S_HOLD, S_INIT, S_RELEASE, S_RUN, S_FAIL}. Counter-width localparams derived via $clog2 of HOLD_CYCLES, STAGE_GAP, INIT_TIMEOUT.
- Sub-module sat_counter (WIDTH, clear, enable, saturate at max), instanced for cnt and uptime_o.
- One FSM always_ff block. stage_rst_o register vector indexed by k.

## Test plan
- Defaults. rst_i high 5 edges then low. init_done_i high sampled on edge 19 → init_req_o=1 after edge 16, 0 after 19. stage_rst_o=110 after 19, 100 after 23, 000 after 27. ready_o=1 after 31. uptime_o=4 after 35.
- Never acknowledge → after edge 1040: timeout_o=1, state FAIL, stage_rst_o=111, ready_o=0, init_req_o=0. Then pulse sw_rst_i → timeout_o stays 1, sequence reruns, init_req_o rises 16 edges later.
- sw_rst_i one edge while in RUN (uptime_o=100) → next edge: stage_rst_o=111, ready_o=0, uptime_o=0. Normal sequence repeats.
- rst_i asserted one edge after stage 0 released → next edge all outputs at reset values. Sequence restarts from HOLD.
- init_done_i held high throughout HOLD → ignored, init_req_o still rises at edge 16. Release occurs on the first INIT edge (edge 17). Separately, done sampled on exactly the 1024th INIT edge → RELEASE, timeout_o stays 0.
- UPTIME_W=4 → uptime_o counts to 15 and holds 15.
